// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: STOP opcode encoding,
// opcode field position and default bus widths.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_STOP = 5'b10111;

  function automatic logic is_stop(input logic [OPC_W-1:0] opc);
    return opc == OPC_STOP;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry prefetch FIFO. Entries shift toward slot 0 on pop, so the head
// is always a plain register (slot 0) with no mux from the write side.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W     = DATA_W_DEF + ADDR_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH*W-1:0] store_q, store_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      wr_idx;
  logic               pop_ok;
  logic               push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign push_ok = push & (~full | pop_ok);
  assign wr_idx  = count_q - CW'(pop_ok);

  always_comb begin
    store_d = store_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop_ok) begin
        store_d = store_q >> W;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (wr_idx == CW'(i))) begin
          store_d[i*W +: W] = wdata;
        end
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_q <= '0;
      count_q <= '0;
    end else begin
      store_q <= store_d;
      count_q <= count_d;
    end
  end

  assign rdata = store_q[W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, prefetch queue and redirect handling.
// Define FETCH_STOP_HALT_EN to stop fetching after a STOP opcode is fetched.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);

  localparam int QW = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              q_full, q_empty;
  logic [QW-1:0]     q_head;
  logic              pop;
  logic              fetch;
  logic              stop_hit;

  assign pop   = ir_valid & ir_ready;
  assign fetch = (~q_full | pop) & ~halted_q & ~redirect;

`ifdef FETCH_STOP_HALT_EN
  assign stop_hit = is_stop(mem_data[OPC_MSB:OPC_LSB]);
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_addr;
      halted_d = 1'b0;
    end else if (fetch) begin
      pc_d = pc_q + 1'b1;
      if (stop_hit) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_queue #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect),
    .push    (fetch),
    .pop     (pop),
    .wdata   ({mem_data, pc_q}),
    .rdata   (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign mem_addr = pc_q;
  assign ir_valid = ~q_empty;
  assign ir_data  = q_head[QW-1:ADDR_W];
  assign ir_pc    = q_head[ADDR_W-1:0];
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// ready/redirect traffic compared each cycle against a queue-level model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  a;
  } ent_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        halted;

  logic [15:0] mem [256];

  ent_t        mq[$];
  logic [7:0]  mpc;
  bit          mhalt;

  int n_vec;
  int n_miss;

  fetch_unit #(
    .ADDR_W (8),
    .DATA_W (16),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halted        (halted)
  );

  assign mem_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = 8'h00;
    mhalt = 1'b0;
  endtask

  // Called at a falling edge: check DUT against the model, apply inputs,
  // advance the model by one cycle, then move to the next falling edge.
  task automatic step(input bit rdy, input bit rd, input logic [7:0] ra);
    int   sz;
    bit   pp;
    ent_t e;
    check("mem_addr", mem_addr, mpc);
    check("ir_valid", ir_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("ir_data", ir_data, mq[0].d);
      check("ir_pc", ir_pc, mq[0].a);
    end
    check("halted", halted, mhalt);
    ir_ready      = rdy;
    redirect      = rd;
    redirect_addr = ra;
    sz = mq.size();
    pp = (sz != 0) && rdy;
    if (pp) $display("accept pc=%02h data=%04h%s", mq[0].a, mq[0].d, rd ? " (redirect)" : "");
    if (rd) begin
      mq.delete();
      mpc   = ra;
      mhalt = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if ((sz < DEPTH || pp) && !mhalt) begin
        e.d = mem[mpc];
        e.a = mpc;
        mq.push_back(e);
`ifdef FETCH_STOP_HALT_EN
        if (e.d[15:11] == 5'b10111) mhalt = 1'b1;
`endif
        mpc = mpc + 8'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    bit          hit;
    bit          rdy;
    bit          rd;
    logic [7:0]  ra;

    n_vec  = 0;
    n_miss = 0;

    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      w[15] = 1'b0;
      if ($urandom_range(0, 15) == 0) w[15:11] = 5'b10111;
      mem[i] = w;
    end
    mem[8'h00] = 16'h1001; mem[8'h01] = 16'h2002; mem[8'h02] = 16'h3000;
    mem[8'h03] = 16'hD101; mem[8'h04] = 16'h4112; mem[8'h05] = 16'h5FFF;
    mem[8'h06] = 16'hC003; mem[8'h07] = 16'h0000; mem[8'h08] = 16'hB800;
    mem[8'hFE] = 16'h6ABC; mem[8'hFF] = 16'h7123;
    for (int i = 16; i < 24; i++) mem[i] = {1'b0, mem[i][14:0]};

    reset_n       = 1'b0;
    ir_ready      = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_ir_data", ir_data, 16'h0000);
    check("rst_ir_pc", ir_pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    reset_n = 1'b1;
    model_reset();

    // Straight fetch from reset
    step(1, 0, 8'h00);
    check("first_valid", ir_valid, 1'b1);
    check("first_pc", ir_pc, 8'h00);
    for (int i = 0; i < 12; i++) step(1, 0, 8'h00);

    // Backpressure
    step(1, 1, 8'h00);
    step(0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00);
    check("bp_pc", mem_addr, 8'(DEPTH));
    check("bp_head", ir_data, mem[0]);
    for (int i = 0; i < 12; i++) step(1, 0, 8'h00);

    // Redirect taken while the JMP at 0x06 is at the head
    step(1, 1, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mq.size() != 0 && mq[0].a == 8'h06) begin
        step(1, 1, 8'h03);
        hit = 1'b1;
      end else begin
        step(1, 0, 8'h00);
      end
    end
    check("jmp_seen", hit, 1'b1);
    check("redir_bubble", ir_valid, 1'b0);
    step(1, 0, 8'h00);
    check("redir_valid", ir_valid, 1'b1);
    check("redir_pc", ir_pc, 8'h03);
    check("redir_data", ir_data, 16'hD101);

    // Run into STOP, then resume via redirect
    step(1, 1, 8'h00);
    for (int i = 0; i < 14; i++) step(1, 0, 8'h00);
`ifdef FETCH_STOP_HALT_EN
    check("stop_halted", halted, 1'b1);
    check("stop_addr", mem_addr, 8'h09);
    check("stop_drained", ir_valid, 1'b0);
`endif
    step(1, 1, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00);

    // PC wrap-around
    step(1, 1, 8'hFE);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00);

    // Random ready / redirect traffic
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 19) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? 8'(8'hFD + $urandom_range(0, 2))
                                        : 8'($urandom_range(0, 255));
      step(rdy, rd, ra);
    end

    // Asynchronous reset while the queue is full
    step(1, 1, 8'h10);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 8'h00);
    check("ar_pre_valid", ir_valid, 1'b1);
    check("ar_pre_pc", mem_addr, 8'(8'h10 + DEPTH));
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_mem_addr", mem_addr, 8'h00);
    check("ar_valid", ir_valid, 1'b0);
    check("ar_ir_data", ir_data, 16'h0000);
    check("ar_ir_pc", ir_pc, 8'h00);
    check("ar_halted", halted, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly downstream of the combinational instruction memory. The block drives the memory's 8-bit address from its program counter and captures the 16-bit instruction word returned in the same cycle. It buffers fetched words in a small prefetch queue and presents them to the decode stage over a valid/ready handshake. It also handles branch/jump redirects from execute and halts fetching after a STOP instruction.

## Interface
- `ADDR_W`, default 8: program counter and memory address width.
- `DATA_W`, default 16: instruction word width.
- `DEPTH`, default 2: prefetch queue entries; must be a power of two and ≥ 1.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `mem_addr` output ADDR_W: address to instruction memory; equals PC.
- `mem_data` input DATA_W: instruction word from memory, valid combinationally for the current `mem_addr`.
- `ir_data` output DATA_W: instruction at the queue head.
- `ir_pc` output ADDR_W: address the head instruction was fetched from.
- `ir_valid` output 1: the queue head holds an instruction.
- `ir_ready` input 1: decode accepts the head this cycle.
- `redirect` input 1: a branch or jump was taken; flush the queue and restart fetch.
- `redirect_addr` input ADDR_W: target PC for the redirect.
- `halted` output 1: fetching is stopped after a STOP instruction.

## Operation
- **Fetch condition:** fetch = queue not full (or a pop this cycle) AND not halted AND not redirect.
- **On fetch:**
  - push {mem_data, PC} into the queue;
  - PC ← PC+1, modulo 2^ADDR_W, so 0xFF wraps to 0x00.
- **Pop:** occurs when `ir_valid` && `ir_ready`. Push and pop in the same cycle are both legal, including when the queue is full; occupancy is then unchanged.
- **Redirect:** has priority over everything.
  - the queue is emptied and `halted` ← 0;
  - PC ← `redirect_addr`;
  - no push occurs that cycle;
  - a simultaneous pop is still considered accepted; it is the branch instruction itself.
- **STOP:** opcode `mem_data[15:11]` == 5'b10111.
  - When a STOP word is pushed, `halted` ← 1 and PC holds at STOP+1.
  - Queued words, including STOP, still drain to decode.
  - Only `redirect` or reset clears `halted`.
- **Outputs:** `ir_data`, `ir_pc` and `ir_valid` come only from the queue head registers. `mem_data` has no combinational path to the decode outputs.

## Timing
- **Reset values:**
  - PC = 0, so `mem_addr` = 0x00;
  - queue empty, `ir_valid` = 0;
  - `ir_data` = 0, `ir_pc` = 0;
  - `halted` = 0.
- **Reset is asynchronous:** it takes effect immediately, including mid-operation, and discards queue contents.
- **Fetch latency:** the word at address A is pushed on the edge where PC = A. `ir_valid` rises one cycle later if the queue was empty.
- **Redirect penalty:** on the redirect edge the queue is flushed, so `ir_valid` = 0 the next cycle. The target word becomes valid one cycle after that, giving one bubble cycle.
- **Stalled decode:** with `ir_ready` = 0, `ir_data` and `ir_pc` stay stable while `ir_valid` = 1. Once the queue fills, PC holds.
- **Sustained throughput:** with `ir_ready` held at 1, one instruction per cycle.

## Configuration
- `FETCH_STOP_HALT_EN`:
  - **Defined:** STOP detection and `halted` behave as in Operation.
  - **Undefined:** no opcode decoding is done and `halted` is tied to 0. Fetch continues sequentially past STOP, and decode is responsible for stopping the core.

## Structure
- **Package `fetch_pkg`:** holds `OPC_STOP` (5'b10111), the opcode field position [15:11], and the default `ADDR_W`/`DATA_W`.
- **Sub-module `fetch_queue`:** a DEPTH-entry synchronous FIFO.
  - data width is DATA_W+ADDR_W;
  - synchronous `flush` input;
  - `full` and `empty` flags;
  - the head is registered.
- **Top level:** PC register, fetch/redirect/halt control, and the queue instance.

## Test plan
- **Reset and straight fetch:** memory holds the multiply program with STOP at 0x08; release reset with `ir_ready` = 1.
  - `ir_pc` sequence is 0x00, 0x01, 0x02, … on consecutive cycles;
  - first `ir_valid` comes one cycle after the first edge.
- **Backpressure:** hold `ir_ready` = 0 for 5 cycles after the first valid.
  - `ir_data` stays at the word for 0x00;
  - PC stops at 0x00+DEPTH;
  - on release, words are delivered in order with no loss or duplicates.
- **Redirect:** assert `redirect` with `redirect_addr` = 0x03 while the head is at 0x06 (JMP) and `ir_ready` = 1.
  - the next cycle has `ir_valid` = 0;
  - the following cycle shows `ir_pc` = 0x03 and `ir_data` = 16'hD101.
- **STOP halt (macro defined):** run to 0x08.
  - `halted` = 1, and `mem_addr` holds at 0x09;
  - the last delivered word is 16'hB800;
  - `ir_valid` then stays 0;
  - a redirect to 0x00 clears `halted` and resumes fetch.
- **Wrap-around:** redirect to 0xFE.
  - delivered `ir_pc` is 0xFE, 0xFF, 0x00.
- **Asynchronous reset mid-operation:** pulse `reset_n` low between clock edges while the queue is full.
  - outputs go to their reset values immediately;
  - fetch restarts from 0x00.
